// File: rtl/hi_host_master.sv
// hi_host_master: initiator end of the 16-bit state-coded host interface bus.
// Turns a command (write or read N words at ep/reg) into the bus sequence
// SETEP -> SETREG -> (SETRVAL words | RDTC -> RDDATA words) -> IDLE.
//
// Ports:
//   if_clock, resetb           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only while idle)
//   cmd_write, cmd_ep, cmd_reg, cmd_len   command fields, latched on accept
//   wr_data/wr_valid/wr_ready  write word stream (wr_ready = 1-cycle consume pulse)
//   rd_data/rd_valid           read word stream, no backpressure
//   done / err                 1-cycle completion / timeout-abort pulses
//   hst_state, hst_ctl         bus state code and control strobes (only [1] used)
//   hst_rdy, hst_data_in       device ready and device-driven data
//   hst_data_out, hst_data_oe  host-driven data and its output enable
// All outputs come straight from registers.
module hi_host_master #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic        if_clock,
  input  logic        resetb,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_ep,
  input  logic [15:0] cmd_reg,
  input  logic [15:0] cmd_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic [3:0]  hst_state,
  output logic [2:0]  hst_ctl,
  input  logic        hst_rdy,
  output logic [15:0] hst_data_out,
  output logic        hst_data_oe,
  input  logic [15:0] hst_data_in
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_SETEP   = 4'd1;
  localparam logic [3:0] ST_SETREG  = 4'd2;
  localparam logic [3:0] ST_SETRVAL = 4'd3;
  localparam logic [3:0] ST_RDDATA  = 4'd4;
  localparam logic [3:0] ST_RDTC    = 4'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_ASETTLE, S_AWAIT, S_ASTROBE, S_AHOLD,
    S_WSETTLE, S_WWAIT, S_WSTROBE, S_RSETTLE, S_RRUN, S_FIN
  } fsm_t;

  // Which address phase the shared S_A* states are serving.
  typedef enum logic [1:0] {PH_EP, PH_REG, PH_TC} phase_t;

  fsm_t          state_reg, state_next;
  phase_t        phase_reg, phase_next;
  logic [SW-1:0] settle_reg, settle_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [15:0]   remain_reg, remain_next;
  logic          write_reg;
  logic [15:0]   ep_reg, addr_reg, len_reg;

  logic [3:0]    hst_state_reg, hst_state_next;
  logic          ctl1_reg, ctl1_next;
  logic          oe_reg, oe_next;
  logic [15:0]   data_out_reg, data_out_next;
  logic          wr_ready_reg, wr_ready_next;
  logic          rd_valid_reg, rd_valid_next;
  logic [15:0]   rd_data_reg, rd_data_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          cmd_ready_reg, cmd_ready_next;

  logic [15:0]   addr_word;
  logic          progress;
  logic          settle_end;
  logic          tmo_hit;

  always_comb begin
    addr_word = len_reg;
    case (phase_reg)
      PH_EP:   addr_word = ep_reg;
      PH_REG:  addr_word = addr_reg;
      default: addr_word = len_reg;
    endcase
  end

  assign settle_end = (settle_reg == SW'(SETTLE - 1));
  assign tmo_hit    = (tmo_reg == TW'(TIMEOUT - 1));

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    settle_next    = settle_reg;
    tmo_next       = tmo_reg + 1'b1;
    remain_next    = remain_reg;
    hst_state_next = hst_state_reg;
    ctl1_next      = 1'b0;
    oe_next        = oe_reg;
    data_out_next  = data_out_reg;
    wr_ready_next  = 1'b0;
    rd_valid_next  = 1'b0;
    rd_data_next   = rd_data_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    cmd_ready_next = cmd_ready_reg;
    progress       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        tmo_next = '0;
        if (cmd_valid) begin
          state_next     = S_ASETTLE;
          phase_next     = PH_EP;
          settle_next    = '0;
          remain_next    = cmd_len;
          hst_state_next = ST_SETEP;
          oe_next        = 1'b0;
          cmd_ready_next = 1'b0;
        end
      end
      S_ASETTLE: begin
        if (settle_end) begin
          state_next    = S_AWAIT;
          oe_next       = 1'b1;
          data_out_next = addr_word;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end
      S_AWAIT: begin
        if (hst_rdy) begin
          state_next = S_ASTROBE;
          ctl1_next  = 1'b1;
          progress   = 1'b1;
          tmo_next   = '0;
        end
      end
      S_ASTROBE: state_next = S_AHOLD;
      S_AHOLD: begin
        // Phase entry: new state code, bus released during settle.
        progress    = 1'b1;
        tmo_next    = '0;
        settle_next = '0;
        oe_next     = 1'b0;
        case (phase_reg)
          PH_EP: begin
            phase_next     = PH_REG;
            state_next     = S_ASETTLE;
            hst_state_next = ST_SETREG;
          end
          PH_REG: begin
            if (len_reg == 16'd0) begin
              state_next = S_FIN;
              done_next  = 1'b1;
            end else if (write_reg) begin
              state_next     = S_WSETTLE;
              hst_state_next = ST_SETRVAL;
            end else begin
              phase_next     = PH_TC;
              state_next     = S_ASETTLE;
              hst_state_next = ST_RDTC;
            end
          end
          default: begin
            state_next     = S_RSETTLE;
            hst_state_next = ST_RDDATA;
          end
        endcase
      end
      S_WSETTLE: begin
        if (settle_end) begin
          state_next = S_WWAIT;
          oe_next    = 1'b1;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end
      S_WWAIT: begin
        // The WWAIT cycle after a strobe doubles as the mandatory gap cycle.
        if (remain_reg == 16'd0) begin
          state_next = S_FIN;
          done_next  = 1'b1;
        end else if (wr_valid && hst_rdy) begin
          state_next    = S_WSTROBE;
          data_out_next = wr_data;
          ctl1_next     = 1'b1;
          wr_ready_next = 1'b1;
          remain_next   = remain_reg - 16'd1;
          progress      = 1'b1;
          tmo_next      = '0;
        end
      end
      S_WSTROBE: state_next = S_WWAIT;
      S_RSETTLE: begin
        if (settle_end) begin
          state_next = S_RRUN;
          ctl1_next  = 1'b1;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end
      S_RRUN: begin
        ctl1_next = 1'b1;
        if (hst_rdy) begin
          rd_data_next  = hst_data_in;
          rd_valid_next = 1'b1;
          remain_next   = remain_reg - 16'd1;
          progress      = 1'b1;
          tmo_next      = '0;
          if (remain_reg == 16'd1) begin
            state_next = S_FIN;
            done_next  = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_next     = S_IDLE;
        cmd_ready_next = 1'b1;
        tmo_next       = '0;
      end
      default: state_next = S_IDLE;
    endcase

    // Abort only when nothing moved this cycle and we were not already finishing.
    if (state_reg != S_IDLE && state_reg != S_FIN && state_next != S_FIN &&
        tmo_hit && !progress) begin
      state_next = S_FIN;
      err_next   = 1'b1;
    end

    if (state_next == S_FIN) begin
      hst_state_next = ST_IDLE;
      ctl1_next      = 1'b0;
      oe_next        = 1'b0;
    end
  end

  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      state_reg     <= S_IDLE;
      phase_reg     <= PH_EP;
      settle_reg    <= '0;
      tmo_reg       <= '0;
      remain_reg    <= '0;
      write_reg     <= 1'b0;
      ep_reg        <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      hst_state_reg <= ST_IDLE;
      ctl1_reg      <= 1'b0;
      oe_reg        <= 1'b0;
      data_out_reg  <= '0;
      wr_ready_reg  <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      cmd_ready_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      settle_reg    <= settle_next;
      tmo_reg       <= tmo_next;
      remain_reg    <= remain_next;
      hst_state_reg <= hst_state_next;
      ctl1_reg      <= ctl1_next;
      oe_reg        <= oe_next;
      data_out_reg  <= data_out_next;
      wr_ready_reg  <= wr_ready_next;
      rd_valid_reg  <= rd_valid_next;
      rd_data_reg   <= rd_data_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      cmd_ready_reg <= cmd_ready_next;
      if (state_reg == S_IDLE && cmd_valid) begin
        write_reg <= cmd_write;
        ep_reg    <= cmd_ep;
        addr_reg  <= cmd_reg;
        len_reg   <= cmd_len;
      end
    end
  end

  assign cmd_ready    = cmd_ready_reg;
  assign wr_ready     = wr_ready_reg;
  assign rd_data      = rd_data_reg;
  assign rd_valid     = rd_valid_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign hst_state    = hst_state_reg;
  assign hst_ctl      = {1'b0, ctl1_reg, 1'b0};
  assign hst_data_out = data_out_reg;
  assign hst_data_oe  = oe_reg;

endmodule

// File: doc/hi_host_master.md
Name: hi_host_master

Overview:
- Initiator (host) end of the 16-bit state-coded host interface bus; drives state code, ctl strobes and data, and samples rdy from the device-side responder.
- Turns high-level commands (write N words to ep/reg; read N words from ep/reg) into the SETEP/SETREG/SETRVAL/RDTC/RDDATA sequence.
- Used in the FPGA-to-FPGA bridge and as the synthesizable bus driver in system benches.

Parameters:
- SETTLE, 2, idle cycles after any state-code change before ctl[1] may assert (min 2).
- TIMEOUT, 1024, cycles waiting for rdy or read data before abort.

Ports:
- if_clock  in  1  interface clock
- resetb  in  1  async active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master idle, command accepted when valid&ready
- cmd_write  in  1  1=register write burst, 0=read burst
- cmd_ep  in  16  endpoint address
- cmd_reg  in  16  register address
- cmd_len  in  16  word count
- wr_data  in  16  write word stream
- wr_valid  in  1  write word available
- wr_ready  out  1  write word consumed (1-cycle pulse)
- rd_data  out  16  read word
- rd_valid  out  1  read word strobe (no backpressure)
- done  out  1  1-cycle pulse, command complete
- err  out  1  1-cycle pulse, command aborted on timeout
- hst_state  out  4  bus state code
- hst_ctl  out  3  bus control; [1]=rdwr strobe, [0],[2]=0
- hst_rdy  in  1  device ready
- hst_data_out  out  16  bus data driven by host
- hst_data_oe  out  1  host drives bus
- hst_data_in  in  16  bus data from device

Behaviour:
- Interface: reset resetb, asynchronous, active-low; clock if_clock.
- Reset values: hst_state=0, hst_ctl=0, hst_data_oe=0, hst_data_out=0, cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, done=0, err=0. All outputs registered.
- State codes: IDLE=0, SETEP=1, SETREG=2, SETRVAL=3, RDDATA=4, RDTC=7.
- FSM: IDLE -> EP -> REG -> (write: WDATA | read: TC -> RDATA) -> FIN -> IDLE. Command fields latched on accept; cmd_ready=0 from accept until FIN.
- Address phases (EP, REG, TC): load hst_state; wait SETTLE cycles; drive hst_data_out = ep/reg/len, oe=1; when hst_rdy=1 assert hst_ctl[1] for exactly 1 cycle; hold data and oe 1 further cycle; then next phase.
- WDATA: hst_state=3, oe=1, after SETTLE. Per word: if wr_valid & hst_rdy, register wr_data onto bus with ctl[1]=1 for 1 cycle, pulse wr_ready same cycle, then 1 gap cycle with ctl[1]=0. Max rate 1 word / 2 cycles. Exactly cmd_len words.
- RDATA: hst_state=4, oe=0, after SETTLE assert ctl[1] continuously. Each cycle with hst_rdy=1: rd_data<=hst_data_in, rd_valid=1 next cycle, remaining--. At remaining=0 drop ctl[1] same cycle as last capture; ignore further rdy.
- FIN: hst_state=0, ctl=0, oe=0, pulse done, cmd_ready=1 next cycle.
- cmd_len=0: EP and REG phases run; WDATA/TC/RDATA skipped; done pulses.
- Timeout: counter clears on every phase entry, ctl[1] handshake and read word; reaching TIMEOUT -> go to FIN with err pulse instead of done; partially transferred words are not retracted.
- Write stall on wr_valid=0 counts toward timeout.
- cmd_valid while busy: ignored (no queueing).
- Async reset mid-command: immediate return to reset values; command lost.
- Counters 16 bit; no wrap (len ≤ 65535).

Test Plan:
- Write ep=0x0003 reg=0x0010 len=2 data {0xBEEF,0x1234}, rdy always 1 -> state sequence 1,2,3,0; ctl[1] single pulse in 1 and 2 with data 0x0003, 0x0010; two ctl[1] pulses in 3 with 0xBEEF,0x1234; two wr_ready; one done.
- Read ep=1 reg=5 len=4, responder model returns 0xA0..0xA3 with rdy gaps -> states 1,2,7,4,0; RDTC data 0x0004; rd_valid 4× with 0xA0..0xA3 in order; ctl[1] low after 4th word; done.
- Write with wr_valid held low 3 cycles mid-burst and rdy low 2 cycles -> no ctl[1] during stall, words intact, single done.
- Read len=3, responder stops after 2 words, TIMEOUT=16 -> 2 rd_valid, err at 16 cycles after last word, state 0, no done.
- cmd_len=0 write -> states 1,2,0, no WDATA, done; cmd_valid during busy ignored.
- resetb asserted mid RDATA -> outputs at reset values same edge; new command after release runs cleanly.
